// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Clock cycles per oversampling tick (integer truncation).
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

    // XOR over data plus parity bit; 0 means the even-parity check holds.
    function automatic logic even_parity(input logic [9:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
module uart_rx_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + CW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + CW'(1);
        end
    end

    // Storage; cleared on reset so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with sticky error flags and an FWFT RX FIFO.
// Optional even-parity slot: define UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          iCE_CLK,
    input  logic                          RST_N,
    input  logic                          RX,
    input  logic                          RD_EN,
    input  logic                          CLR_ERR,
    output logic [DATA_BITS-1:0]          REC_BYTE,
    output logic                          RECEIVED,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          OVERRUN,
    output logic                          FRAME_ERR,
    output logic                          PARITY_ERR
);

    import uart_rx_pkg::*;

    localparam int unsigned DIV  = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned TC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SC_W = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W = $clog2(DATA_BITS);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_fifo: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 1");
    end

    logic                 rx_meta_q;
    logic                 rx_sync_q;
    logic [TC_W-1:0]      tick_cnt_q;
    logic                 tick_c;
    rx_state_t            state_q,      state_d;
    logic [SC_W-1:0]      sample_cnt_q, sample_cnt_d;
    logic [BC_W-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q,      shreg_d;
    logic                 bit_end_c;
    logic                 push_c;
    logic                 set_ferr_c;
    logic                 drop_c;
    logic                 ovr_q;
    logic                 ferr_q;
    logic                 fifo_full;
    logic                 fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q,    par_bad_d;
    logic                 set_perr_c;
    logic                 perr_q;
`endif

    // Two-flop synchroniser, idle-high reset.
    always_ff @(posedge iCE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign tick_c = (tick_cnt_q == TC_W'(DIV - 1));

    // Free-running oversampling tick divider.
    always_ff @(posedge iCE_CLK or negedge RST_N) begin
        if (!RST_N)      tick_cnt_q <= '0;
        else if (tick_c) tick_cnt_q <= '0;
        else             tick_cnt_q <= tick_cnt_q + TC_W'(1);
    end

    // Framer state and datapath registers.
    always_ff @(posedge iCE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    assign bit_end_c = tick_c && (sample_cnt_q == SC_W'(OVERSAMPLE - 1));

    // Framer next-state and per-frame strobes.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        push_c       = 1'b0;
        set_ferr_c   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        set_perr_c   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d      = START;
                    sample_cnt_d = '0;
                end
            end
            START: begin
                if (tick_c) begin
                    if (sample_cnt_q == SC_W'(OVERSAMPLE / 2 - 1)) begin
                        // Mid-start-bit check rejects short glitches.
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                        state_d      = rx_sync_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                        par_bad_d    = 1'b0;
`endif
                    end else begin
                        sample_cnt_d = sample_cnt_q + SC_W'(1);
                    end
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    sample_cnt_d = '0;
                    shreg_d      = {rx_sync_q, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d    = bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else if (tick_c) begin
                    sample_cnt_d = sample_cnt_q + SC_W'(1);
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (bit_end_c) begin
                    sample_cnt_d = '0;
                    par_bad_d    = even_parity(10'({rx_sync_q, shreg_q}));
                    state_d      = STOP;
                end else if (tick_c) begin
                    sample_cnt_d = sample_cnt_q + SC_W'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (bit_end_c) begin
                    sample_cnt_d = '0;
                    if (rx_sync_q) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) set_perr_c = 1'b1;
                        else           push_c     = 1'b1;
`else
                        push_c = 1'b1;
`endif
                    end else begin
                        set_ferr_c = 1'b1;
                        state_d    = BREAK;
                    end
                end else if (tick_c) begin
                    sample_cnt_d = sample_cnt_q + SC_W'(1);
                end
            end
            BREAK: begin
                if (rx_sync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO drops the byte unless the head is popped in the same cycle.
    assign drop_c = push_c && fifo_full && !RD_EN;

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge iCE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (drop_c)        ovr_q  <= 1'b1;
            else if (CLR_ERR)  ovr_q  <= 1'b0;
            if (set_ferr_c)    ferr_q <= 1'b1;
            else if (CLR_ERR)  ferr_q <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error flag.
    always_ff @(posedge iCE_CLK or negedge RST_N) begin
        if (!RST_N)          perr_q <= 1'b0;
        else if (set_perr_c) perr_q <= 1'b1;
        else if (CLR_ERR)    perr_q <= 1'b0;
    end
    assign PARITY_ERR = perr_q;
`else
    assign PARITY_ERR = 1'b0;
`endif

    uart_rx_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (iCE_CLK),
        .rst_n (RST_N),
        .push  (push_c),
        .wdata (shreg_q),
        .pop   (RD_EN),
        .rdata (REC_BYTE),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (FIFO_COUNT)
    );

    assign RECEIVED  = !fifo_empty;
    assign OVERRUN   = ovr_q;
    assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo against a frame-level queue model.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ = 12000000;
    localparam int unsigned BAUD     = 750000;
    localparam int unsigned OS       = 16;
    localparam int unsigned DB       = 8;
    localparam int unsigned DEPTH    = 4;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned NBITS     = 1 + DB + PAR + 1;
    localparam int unsigned FRAME_CYC = NBITS * OS;
    // Edges after the start-bit launch edge: 2 sync, 1 idle detect, half a bit, then whole bits up to stop.
    localparam int unsigned STOP_EDGE = 3 + OS / 2 + (DB + PAR + 1) * OS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic          rd_en;
    logic          clr_err;
    logic [DB-1:0] rec_byte;
    logic          received;
    logic [2:0]    fifo_count;
    logic          overrun;
    logic          frame_err;
    logic          parity_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    bit         m_ovr;
    bit         m_ferr;
    bit         m_perr;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .iCE_CLK    (clk),
        .RST_N      (rst_n),
        .RX         (rx),
        .RD_EN      (rd_en),
        .CLR_ERR    (clr_err),
        .REC_BYTE   (rec_byte),
        .RECEIVED   (received),
        .FIFO_COUNT (fifo_count),
        .OVERRUN    (overrun),
        .FRAME_ERR  (frame_err),
        .PARITY_ERR (parity_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"},    32'(fifo_count), 32'(mq.size()));
        check({tag, ".received"}, 32'(received),   32'(mq.size() != 0));
        check({tag, ".overrun"},  32'(overrun),    32'(m_ovr));
        check({tag, ".frame"},    32'(frame_err),  32'(m_ferr));
        check({tag, ".parity"},   32'(parity_err), 32'(m_perr));
        if (mq.size() != 0) check({tag, ".head"}, 32'(rec_byte), 32'(mq[0]));
    endtask

    // Frame-level model: pop (if requested) happens alongside the push decision.
    task automatic model_frame(input logic [7:0] data, input bit stop, input bit par, input bit pop_at_push);
        bit par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_ok = (((^data) ^ par) == 1'b0);
`endif
        if (pop_at_push && mq.size() != 0) void'(mq.pop_front());
        if (!stop)        m_ferr = 1'b1;
        else if (!par_ok) m_perr = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(data);
        else              m_ovr = 1'b1;
    endtask

    // Drives one frame starting just after a clock edge; optionally pops on the push edge.
    task automatic send_frame(input logic [7:0] data, input bit stop, input bit par,
                              input bit pop_at_push, input bit chk_lat);
        logic [15:0] bits;
        bits = '0;
        for (int i = 0; i < int'(DB); i++) bits[1 + i] = data[i];
`ifdef UART_RX_PARITY_EN
        bits[1 + DB] = par;
`endif
        bits[NBITS - 1] = stop;
        rx = 1'b0;
        for (int k = 1; k <= int'(FRAME_CYC); k++) begin
            @(posedge clk);
            #1;
            if (chk_lat && k == int'(STOP_EDGE) - 1) check("lat.pre_received", 32'(received), 32'(0));
            if (chk_lat && k == int'(STOP_EDGE)) begin
                check("lat.received", 32'(received), 32'(1));
                check("lat.byte", 32'(rec_byte), 32'(data));
            end
            if (pop_at_push && k == int'(STOP_EDGE) - 1 && mq.size() != 0)
                check("pushpop.head", 32'(rec_byte), 32'(mq[0]));
            rd_en = pop_at_push && (k == int'(STOP_EDGE) - 1);
            if (k < int'(FRAME_CYC)) rx = bits[k / int'(OS)];
        end
        rd_en = 1'b0;
        model_frame(data, stop, par, pop_at_push);
    endtask

    task automatic send_ok(input logic [7:0] data);
        send_frame(data, 1'b1, ^data, 1'b0, 1'b0);
    endtask

    task automatic pop_one(input string tag);
        if (mq.size() != 0) check({tag, ".pop_head"}, 32'(rec_byte), 32'(mq[0]));
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        check({tag, ".pop_count"}, 32'(fifo_count), 32'(mq.size()));
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         par;
        rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
        step(3);
        check("reset.byte", 32'(rec_byte), 32'(0));
        check_state("reset");
        rst_n = 1'b1;
        step(4);

        // Single byte with exact push latency, then pop to empty.
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, 1'b1);
        check_state("a5");
        pop_one("a5");
        check_state("a5.empty");

        // Overflow: fifth byte dropped.
        for (int i = 1; i <= 5; i++) send_ok(8'(i));
        check_state("ovf");
        for (int i = 0; i < 4; i++) pop_one("ovf");
        check_state("ovf.drained");
        pop_one("empty_pop");
        clear_err();
        check_state("ovf.clr");

        // Full FIFO, pop exactly on the push edge of 0x55.
        for (int i = 0; i < 4; i++) send_ok(8'h11 + 8'(i));
        send_frame(8'h55, 1'b1, ^8'h55, 1'b1, 1'b0);
        check_state("pushpop");
        for (int i = 0; i < 4; i++) pop_one("pushpop");
        check_state("pushpop.drained");

        // Stop bit low: frame error, line held in break, then recovery.
        send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0, 1'b0);
        step(40);
        check_state("break");
        rx = 1'b1;
        step(20);
        send_ok(8'h66);
        check_state("after_break");
        clear_err();
        check_state("ferr.clr");
        pop_one("x66");

        // Short low glitch on an idle line.
        rx = 1'b0;
        step(3);
        rx = 1'b1;
        step(30);
        check_state("glitch");
        send_ok(8'hC3);
        check_state("after_glitch");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        check_state("par.bad");
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        check_state("par.good");
        clear_err();
        check_state("par.clr");
`endif

        // Randomized traffic with random pops and occasional pop-on-push.
        for (int it = 0; it < 24; it++) begin
            int npop;
            bit pap;
            npop = $urandom_range(0, 2);
            for (int j = 0; j < npop; j++) pop_one("rnd");
            d   = 8'($urandom);
            par = ^d;
`ifdef UART_RX_PARITY_EN
            if ($urandom_range(0, 4) == 0) par = ~par;
`endif
            pap = ($urandom_range(0, 3) == 0);
            send_frame(d, 1'b1, par, pap, 1'b0);
            check_state("rnd");
            if ($urandom_range(0, 5) == 0) clear_err();
        end

        // Reset asserted in the middle of a frame.
        rx = 1'b0;
        step(50);
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
        check("midrst.byte", 32'(rec_byte), 32'(0));
        check_state("midrst");
        rx = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(5);
        send_ok(8'h5A);
        check_state("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a built-in oversampling framer and an RX FIFO. It replaces the fixed 9600-baud, single-byte receive path that latches one byte on a strobe. Serial bytes are framed, checked and queued; the host drains them through a first-word-fall-through pop interface. It sits between the board RX pin and the command decoder, in the iCE_CLK domain.

## Interface
- CLK_FREQ, 12000000: iCE_CLK frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s.
- OVERSAMPLE, 16: ticks per bit; even, ≥4.
- DATA_BITS, 8: payload bits per frame, 5–9.
- FIFO_DEPTH, 16: entries; power of two, ≥2.

- iCE_CLK  in  1  sole clock.
- RST_N  in  1  asynchronous, active-low reset.
- RX  in  1  serial line, asynchronous, idle high.
- RD_EN  in  1  pop the head entry.
- CLR_ERR  in  1  clear sticky error flags.
- REC_BYTE  out  DATA_BITS  head entry of the FIFO (FWFT).
- RECEIVED  out  1  FIFO non-empty.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  occupancy.
- OVERRUN  out  1  sticky: a byte was dropped because the FIFO was full.
- FRAME_ERR  out  1  sticky: stop bit sampled low.
- PARITY_ERR  out  1  sticky: parity mismatch. Constant 0 without the parity option.

## Operation
- RX passes through a 2-flop synchroniser; both flops reset to 1.
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation, elaboration error if DIV<1. The counter counts 0..DIV-1 and emits a 1-cycle tick at DIV-1.
- Framer states are IDLE, START, DATA, PARITY, STOP and BREAK. Within a frame a sample counter counts ticks.
  - IDLE: synchronised RX=0 → START, with the sample count cleared.
  - START: at tick OVERSAMPLE/2-1, RX=0 → DATA; RX=1 → IDLE (glitch reject).
  - DATA: one sample every OVERSAMPLE ticks, LSB first, into a shift register. After DATA_BITS samples → PARITY if the option is compiled in, else → STOP.
  - PARITY: even parity over data plus parity bit; a mismatch sets a per-frame flag → STOP.
  - STOP: RX=1 with no parity flag → push the byte, go to IDLE. RX=1 with the parity flag → set PARITY_ERR, discard the byte, go to IDLE. RX=0 → set FRAME_ERR, discard the byte, go to BREAK.
  - BREAK: wait for synchronised RX=1 → IDLE.
- FIFO: circular buffer with wrapping read/write pointers one bit wider than the address.
  - Push while full without a same-cycle pop: byte dropped, OVERRUN set, contents unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun, count unchanged.
  - Push and pop in the same cycle while non-full and non-empty: count unchanged.
  - RD_EN while empty: ignored.
- CLR_ERR clears all sticky flags. If a new error occurs in the same cycle, the error wins (flag stays 1).

## Timing
- Reset values: REC_BYTE 0, RECEIVED 0, FIFO_COUNT 0, all error flags 0. Framer in IDLE; tick counter, sample counter and pointers all 0.
- Reset asserted mid-frame aborts the frame and flushes the FIFO. After release, reception restarts at the next falling edge.
- RX-to-framer latency is 2 cycles (synchroniser).
- A pushed byte appears on REC_BYTE, with RECEIVED=1, in the cycle after the stop-bit sample edge.
- Pop: REC_BYTE and FIFO_COUNT update on the clock edge where RD_EN=1. RECEIVED drops on the same edge if the FIFO empties.
- Error flags assert on the edge after the offending sample.
- The framer accepts back-to-back frames: a new start bit is recognised the cycle after STOP returns to IDLE.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state present, a 1-bit even-parity slot follows the data bits, and PARITY_ERR is live.
- Undefined: frame is start, data, stop; PARITY_ERR is tied 0 and the PARITY state logic is removed.

## Structure
- Package uart_rx_pkg holds:
  - the framer state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - a function computing DIV from the parameters;
  - an even-parity helper function.
- Sub-module uart_rx_sync_fifo: parametrised by width and depth. It has push/pop/full/empty/count ports and implements the FWFT read and all full/empty/simultaneous rules above. The top level contains the synchroniser, tick generator, framer and error flags.

## Test plan
All scenarios use CLK_FREQ=12000000, BAUD_RATE=750000, OVERSAMPLE=16 (DIV=1), DATA_BITS=8, FIFO_DEPTH=4.
- Reset, then send 0xA5 → REC_BYTE=0xA5, RECEIVED=1, FIFO_COUNT=1 one cycle after the stop sample. RD_EN pulse → RECEIVED=0, FIFO_COUNT=0.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 without popping → FIFO_COUNT=4, OVERRUN=1. Pops return 0x01–0x04; 0x05 is lost.
- FIFO full, RD_EN asserted in the exact push cycle of 0x55 → no OVERRUN, FIFO_COUNT stays 4, 0x55 is read last.
- Hold the stop bit low for one frame of 0x3C → FRAME_ERR=1, FIFO_COUNT unchanged. Framer stays in BREAK until RX=1. Next frame 0x66 is received correctly. CLR_ERR → FRAME_ERR=0.
- 3-cycle low glitch on idle RX → no byte pushed, framer back in IDLE. Assert RST_N=0 mid-frame → all outputs at reset values immediately.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong) → PARITY_ERR=1, byte discarded. Send 0x07 with parity bit 1 → byte pushed, PARITY_ERR stays 1 until CLR_ERR.
